pc_tx_packetiser: RTL and testbench



---
 rtl/pc_tx_packetiser.sv | 221 ++++++++++++++++++++++
 tb/tb_pc_tx_packetiser.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_tx_packetiser.sv
// pc_tx_packetiser
//   Sends one packet to the FTDI USB2 bridge as 8N1 UART. A packet is a header
//   word {SYNC_BYTE, command, 6'b0, length} followed by `length` payload words.
//   Words leave the block MSB byte first, and each byte leaves LSB bit first.
//
// Ports
//   i_clock          system clock (50 MHz)
//   i_reset          synchronous, active-high reset
//   i_packet_start   1-cycle pulse that begins a packet; ignored while o_busy=1
//   i_packet_command command field, sampled together with i_packet_start
//   i_packet_length  payload word count, sampled together with i_packet_start
//   i_word_valid     a payload word is available on i_word_data
//   i_word_data      payload word
//   o_word_ready     a word is taken this cycle if i_word_valid=1
//   o_tx_serial      UART line to the PC, idles high
//   o_busy           high while a packet is in flight
//   o_packet_done    1-cycle pulse after the final stop bit
//
// Packet FSM
//   state       | meaning
//   ------------+-------------------------------------------------------
//   S_IDLE      | line high, waiting for i_packet_start
//   S_SEND_HDR  | bit engine is shifting out the 4 header bytes
//   S_WAIT_WORD | o_word_ready high, line high, waiting for i_word_valid
//   S_SEND_WORD | bit engine is shifting out the 4 bytes of a payload word
//   S_DONE      | one cycle: raise o_packet_done, drop o_busy

module pc_tx_packetiser #(
  parameter int unsigned CLKS_PER_BIT = 435,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_packet_start,
  input  logic [1:0]  i_packet_command,
  input  logic [15:0] i_packet_length,
  input  logic        i_word_valid,
  input  logic [31:0] i_word_data,
  output logic        o_word_ready,
  output logic        o_tx_serial,
  output logic        o_busy,
  output logic        o_packet_done
);

  localparam int unsigned       BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_HDR,
    S_WAIT_WORD,
    S_SEND_WORD,
    S_DONE
  } pkt_state_t;

  typedef enum logic [1:0] {
    B_START,
    B_DATA,
    B_STOP
  } bit_phase_t;

  pkt_state_t        state_q, state_d;
  bit_phase_t        phase_q, phase_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       shift_q, shift_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;

  logic              baud_tc;
  logic              word_end;
  logic [7:0]        cur_byte;
  logic [2:0]        idx_inc;

  assign baud_tc  = (baud_q == BAUD_LAST);
  assign cur_byte = shift_q[31:24];
  assign idx_inc  = bit_idx_q + 3'd1;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bit_idx_d  = bit_idx_q;
    baud_d     = baud_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    word_end   = 1'b0;

    // Bit engine. The next line level is computed together with the bit
    // advance so o_tx_serial can be a plain flop with no output decode.
    if (state_q == S_SEND_HDR || state_q == S_SEND_WORD) begin
      if (baud_tc) begin
        baud_d = '0;
        case (phase_q)
          B_START: begin
            phase_d   = B_DATA;
            bit_idx_d = 3'd0;
            tx_d      = cur_byte[0];
          end
          B_DATA: begin
            if (bit_idx_q == 3'd7) begin
              phase_d = B_STOP;
              tx_d    = 1'b1;
            end else begin
              bit_idx_d = idx_inc;
              tx_d      = cur_byte[idx_inc];
            end
          end
          B_STOP: begin
            if (byte_idx_q == 2'd3) begin
              word_end = 1'b1;
            end else begin
              // Next byte of the same word starts straight after the stop bit.
              byte_idx_d = byte_idx_q + 2'd1;
              shift_d    = {shift_q[23:0], 8'h00};
              phase_d    = B_START;
              tx_d       = 1'b0;
            end
          end
          default: phase_d = B_START;
        endcase
      end else begin
        baud_d = baud_q + BAUD_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (i_packet_start && !busy_q) begin
          shift_d    = {SYNC_BYTE, i_packet_command, 6'b0, i_packet_length};
          len_d      = i_packet_length;
          word_cnt_d = '0;
          busy_d     = 1'b1;
          tx_d       = 1'b0;
          phase_d    = B_START;
          baud_d     = '0;
          byte_idx_d = '0;
          bit_idx_d  = '0;
          state_d    = S_SEND_HDR;
        end
      end
      S_SEND_HDR, S_SEND_WORD: begin
        if (word_end) begin
          // word_cnt counts words already taken, so equality means the
          // word just sent was the last one (or the header of an empty packet).
          if (word_cnt_q == len_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT_WORD;
            ready_d = 1'b1;
          end
        end
      end
      S_WAIT_WORD: begin
        if (i_word_valid) begin
          shift_d    = i_word_data;
          word_cnt_d = word_cnt_q + 16'd1;
          ready_d    = 1'b0;
          tx_d       = 1'b0;
          phase_d    = B_START;
          baud_d     = '0;
          byte_idx_d = '0;
          bit_idx_d  = '0;
          state_d    = S_SEND_WORD;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      phase_q    <= B_START;
      bit_idx_q  <= '0;
      baud_q     <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_idx_q  <= bit_idx_d;
      baud_q     <= baud_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
  end

  assign o_tx_serial   = tx_q;
  assign o_busy        = busy_q;
  assign o_word_ready  = ready_q;
  assign o_packet_done = done_q;

endmodule

// File: tb/tb_pc_tx_packetiser.sv
// Bench for pc_tx_packetiser with a short bit period. A line monitor decodes
// UART frames from o_tx_serial and timestamps them; expected bytes and frame
// start times are built from the packet format and latency rules.
module tb_pc_tx_packetiser;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_packet_start;
  logic [1:0]  i_packet_command;
  logic [15:0] i_packet_length;
  logic        i_word_valid;
  logic [31:0] i_word_data;
  logic        o_word_ready;
  logic        o_tx_serial;
  logic        o_busy;
  logic        o_packet_done;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  rx_byte_q[$];
  int          rx_start_q[$];
  bit          rx_ok_q[$];
  int          acc_q[$];
  int          done_q[$];
  int          ready_cycles = 0;
  bit          mon_en = 1'b0;
  logic [31:0] stim_words[$];

  pc_tx_packetiser #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .i_clock         (clk),
    .i_reset         (i_reset),
    .i_packet_start  (i_packet_start),
    .i_packet_command(i_packet_command),
    .i_packet_length (i_packet_length),
    .i_word_valid    (i_word_valid),
    .i_word_data     (i_word_data),
    .o_word_ready    (o_word_ready),
    .o_tx_serial     (o_tx_serial),
    .o_busy          (o_busy),
    .o_packet_done   (o_packet_done)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // Line monitor: sampled mid-cycle, records handshakes, done pulses and frames.
  initial begin : mon_blk
    bit         in_frame;
    bit         ok;
    int         fcnt;
    int         fstart;
    logic       samp [FRAME];
    logic [7:0] b;
    in_frame = 0; fcnt = 0; fstart = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        in_frame = 0;
      end else begin
        if (o_word_ready) ready_cycles++;
        if (o_word_ready && i_word_valid) acc_q.push_back(cyc);
        if (o_packet_done) done_q.push_back(cyc);
        if (!in_frame && o_tx_serial === 1'b0) begin
          in_frame = 1; fcnt = 0; fstart = cyc;
        end
        if (in_frame) begin
          samp[fcnt] = o_tx_serial;
          fcnt++;
          if (fcnt == FRAME) begin
            ok = 1;
            for (int k = 0; k < 10; k++)
              for (int j = 1; j < CPB; j++)
                if (samp[k*CPB+j] !== samp[k*CPB]) ok = 0;
            if (samp[0] !== 1'b0) ok = 0;
            if (samp[9*CPB] !== 1'b1) ok = 0;
            for (int k = 0; k < 8; k++) b[k] = samp[(k+1)*CPB];
            rx_byte_q.push_back(b);
            rx_start_q.push_back(fstart);
            rx_ok_q.push_back(ok);
            in_frame = 0;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One packet using stim_words as payload. b2b=1 means the caller is in the
  // cycle right after the previous done pulse and start is driven now.
  task automatic run_packet(input logic [1:0] cmd, input logic [15:0] len,
                            input int max_gap, input bit extra_start,
                            input bit long_gap, input bit b2b);
    logic [7:0] exp_b[$];
    int rx_base, acc_base, done_base, rdy_base, t_start, d, gap, exp_s, nb;
    bit got, prev_busy, steady;

    exp_b.push_back(8'hA5);
    exp_b.push_back({cmd, 6'b0});
    exp_b.push_back(len[15:8]);
    exp_b.push_back(len[7:0]);
    for (int w = 0; w < int'(len); w++)
      for (int k = 3; k >= 0; k--) exp_b.push_back(stim_words[w][8*k +: 8]);

    if (!b2b) begin @(posedge clk); #1; end
    rx_base = rx_byte_q.size(); acc_base = acc_q.size();
    done_base = done_q.size(); rdy_base = ready_cycles;

    i_packet_command = cmd;
    i_packet_length  = len;
    i_word_valid     = (max_gap == 0 && !long_gap);
    i_word_data      = (len > 0) ? stim_words[0] : 32'hFFFF_FFFF;
    i_packet_start   = 1'b1;
    t_start          = cyc;
    @(posedge clk); #1;
    i_packet_start = 1'b0;
    @(negedge clk);
    chk("start_tx_low", o_tx_serial, 1'b0);
    chk("start_busy", o_busy, 1'b1);

    if (extra_start) begin
      repeat (3) @(posedge clk);
      #1;
      i_packet_command = ~cmd;
      i_packet_length  = len + 16'd5;
      i_packet_start   = 1'b1;
      @(posedge clk); #1;
      i_packet_start   = 1'b0;
      i_packet_command = cmd;
      i_packet_length  = len;
    end

    for (int w = 0; w < int'(len); w++) begin
      i_word_data = stim_words[w];
      if (long_gap) begin
        i_word_valid = 1'b0;
        got = 0;
        for (int k = 0; k < 2000 && !got; k++) begin @(negedge clk); got = o_word_ready; end
        chk("gap_ready_seen", got, 1'b1);
        steady = 1;
        for (int k = 0; k < 100; k++) begin
          @(negedge clk);
          if (o_tx_serial !== 1'b1 || o_word_ready !== 1'b1) steady = 0;
        end
        chk("gap_line_idle", steady, 1'b1);
        @(posedge clk); #1;
      end else if (max_gap > 0) begin
        gap = $urandom_range(0, max_gap);
        repeat (gap) begin @(posedge clk); #1; end
      end
      i_word_valid = 1'b1;
      got = 0;
      for (int k = 0; k < 2000 && !got; k++) begin
        @(negedge clk); got = o_word_ready;
        @(posedge clk); #1;
      end
      chk("word_accept", got, 1'b1);
      if (max_gap > 0 || long_gap) i_word_valid = 1'b0;
    end

    got = 0; prev_busy = 0;
    for (int k = 0; k < int'(len) * 3000 + 3000 && !got; k++) begin
      @(negedge clk);
      if (o_packet_done) got = 1; else prev_busy = o_busy;
    end
    chk("done_seen", got, 1'b1);
    d = cyc;
    chk("busy_before_done", prev_busy, 1'b1);
    chk("busy_at_done", o_busy, 1'b0);
    @(negedge clk);
    chk("done_single", o_packet_done, 1'b0);
    chk("done_count", done_q.size() - done_base, 1);
    i_word_valid = 1'b0;

    nb = rx_byte_q.size() - rx_base;
    chk("byte_count", nb, exp_b.size());
    if (nb == exp_b.size()) begin
      for (int i = 0; i < nb; i++) begin
        chk($sformatf("byte_val[%0d]", i), rx_byte_q[rx_base+i], exp_b[i]);
        chk($sformatf("frame_ok[%0d]", i), rx_ok_q[rx_base+i], 1'b1);
        if (i == 0) exp_s = t_start + 1;
        else if (i % 4 != 0) exp_s = rx_start_q[rx_base+i-1] + FRAME;
        else exp_s = (acc_q.size() > acc_base + i/4 - 1) ? acc_q[acc_base + i/4 - 1] + 1 : -1;
        chk($sformatf("frame_time[%0d]", i), rx_start_q[rx_base+i], exp_s);
      end
      chk("done_time", d, rx_start_q[rx_base+nb-1] + FRAME + 1);
    end
    chk("words_accepted", acc_q.size() - acc_base, len);
    if (len == 0) chk("len0_duration", d - t_start, 40*CPB + 2);
    if (max_gap == 0 && !long_gap) chk("ready_cycles", ready_cycles - rdy_base, len);
  endtask

  task automatic fill_random(input int n);
    stim_words.delete();
    for (int i = 0; i < n; i++) stim_words.push_back($urandom);
  endtask

  initial begin : main_blk
    int acc;
    int dones;
    int readies;
    logic [31:0] w0;
    logic [1:0]  rcmd;
    logic [15:0] rlen;

    i_reset = 1'b1; i_packet_start = 1'b0; i_packet_command = 2'b00;
    i_packet_length = 16'd0; i_word_valid = 1'b0; i_word_data = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", o_tx_serial, 1'b1);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_ready", o_word_ready, 1'b0);
    chk("rst_done", o_packet_done, 1'b0);
    @(posedge clk); #1;
    i_reset = 1'b0;
    mon_en  = 1'b1;

    // Empty packet, valid held high throughout: header only.
    stim_words.delete();
    run_packet(2'b01, 16'd0, 0, 0, 0, 0);

    // Two fixed words, valid held high.
    stim_words.delete();
    stim_words.push_back(32'hDEADBEEF);
    stim_words.push_back(32'h01234567);
    run_packet(2'b00, 16'd2, 0, 0, 0, 0);

    // Long idle gap before the only word.
    fill_random(1);
    run_packet(2'b11, 16'd1, 0, 0, 1, 0);

    // Second start during the header must be ignored.
    fill_random(3);
    run_packet(2'b10, 16'd3, 3, 1, 0, 0);

    // Reset during data bit 3 of byte 2 of the first payload word.
    mon_en = 1'b0;
    w0 = 32'hC3A5_375A;
    @(posedge clk); #1;
    i_packet_command = 2'b10; i_packet_length = 16'd2;
    i_word_data = w0; i_word_valid = 1'b1; i_packet_start = 1'b1;
    @(posedge clk); #1;
    i_packet_start = 1'b0;
    acc = -1;
    for (int k = 0; k < 2000 && acc < 0; k++) begin
      @(negedge clk);
      if (o_word_ready) acc = cyc;
    end
    chk("rst_ready_seen", acc >= 0, 1'b1);
    repeat (97) @(negedge clk);
    chk("rst_bit3_val", o_tx_serial, w0[11]);
    i_reset = 1'b1; i_word_valid = 1'b0;
    @(posedge clk); #1;
    i_reset = 1'b0;
    @(negedge clk);
    chk("midrst_tx", o_tx_serial, 1'b1);
    chk("midrst_busy", o_busy, 1'b0);
    chk("midrst_ready", o_word_ready, 1'b0);
    chk("midrst_done", o_packet_done, 1'b0);
    dones = 0; readies = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (o_packet_done) dones++;
      if (o_word_ready || !o_tx_serial) readies++;
    end
    chk("midrst_no_done", dones, 0);
    chk("midrst_quiet", readies, 0);
    mon_en = 1'b1;

    // Clean packet after the reset.
    fill_random(2);
    run_packet(2'b01, 16'd2, 2, 0, 0, 0);

    // Back-to-back packets.
    fill_random(1);
    run_packet(2'b10, 16'd1, 0, 0, 0, 0);
    fill_random(2);
    run_packet(2'b11, 16'd2, 1, 0, 0, 1);

    // Random packets.
    for (int r = 0; r < 4; r++) begin
      rcmd = 2'($urandom_range(0, 3));
      rlen = 16'($urandom_range(0, 3));
      fill_random(int'(rlen));
      run_packet(rcmd, rlen, $urandom_range(0, 4), 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
